// File: rtl/axis_burst_framer_pkg.sv
// Shared types and helpers for the transmit-path framer.
// Provides the framer state encoding, default sync pattern and header builder.
package transmit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_GAP     = 2'd3
  } framer_state_t;

  localparam logic [15:0] SYNC_DEFAULT = 16'hA5C3;

  // Header word: sync pattern in the upper half, frame sequence number below.
  function automatic logic [31:0] make_header(input logic [15:0] seq,
                                              input logic [15:0] sync = SYNC_DEFAULT);
    return {sync, seq};
  endfunction

endpackage

// File: rtl/axis_burst_framer.sv
// Drains fixed-length bursts from the transmit FIFO and emits them as framed
// AXI4-Stream packets: one header beat, BURST_LEN payload beats, then a gap.
module axis_burst_framer
  import transmit_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int          COUNT_W    = 32,
  parameter int          BURST_LEN  = 256,
  parameter int          GAP_CYCLES = 4,
  parameter logic [15:0] SYNC       = SYNC_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic [COUNT_W-1:0] fifo_rd_data_count,
  input  logic               fifo_prog_empty,
  output logic [DATA_W-1:0]  m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic [15:0]        frame_seq,
  output logic               busy
);

  localparam int BEAT_W  = $clog2(BURST_LEN + 1);
  localparam int GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam bit HAS_GAP = (GAP_CYCLES > 0);
  localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [COUNT_W-1:0] START_THR = COUNT_W'(BURST_LEN);

  framer_state_t      state_r;
  framer_state_t      state_s;
  logic               start_ok_r;
  logic [BEAT_W-1:0]  beat_cnt_r;
  logic [GAP_W-1:0]   gap_cnt_r;
  logic [15:0]        frame_seq_r;
  logic [31:0]        hdr32_s;
  logic [DATA_W-1:0]  hdr_word_s;
  logic               last_beat_s;
  logic               pay_hs_s;
  logic               hdr_hs_s;

  assign hdr32_s     = make_header(frame_seq_r, SYNC);
  assign last_beat_s = (beat_cnt_r == BEAT_LAST);
  assign pay_hs_s    = (state_r == ST_PAYLOAD) && s_axis_tvalid && m_axis_tready;
  assign hdr_hs_s    = (state_r == ST_HEADER) && m_axis_tready;
  assign frame_seq   = frame_seq_r;
  assign busy        = (state_r != ST_IDLE);

  generate
    if (DATA_W > 32) begin : g_hdr_ext
      assign hdr_word_s = {{(DATA_W - 32){1'b0}}, hdr32_s};
    end else begin : g_hdr_trunc
      assign hdr_word_s = hdr32_s[DATA_W-1:0];
    end
  endgenerate

  // Start condition is only sampled in IDLE so a lagging count cannot retrigger.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_ok_r <= 1'b0;
    end else if (state_r == ST_IDLE) begin
      start_ok_r <= (fifo_rd_data_count >= START_THR) && !fifo_prog_empty;
    end else begin
      start_ok_r <= 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode and stream steering; payload is a zero-latency pass-through.
  always_comb begin
    state_s       = state_r;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = {DATA_W{1'b0}};
    m_axis_tlast  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_r) begin
          state_s = ST_HEADER;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HEADER: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_word_s;
        if (m_axis_tready) begin
          state_s = ST_PAYLOAD;
        end else begin
          state_s = ST_HEADER;
        end
      end
      ST_PAYLOAD: begin
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        s_axis_tready = m_axis_tready;
        m_axis_tlast  = last_beat_s;
        if (pay_hs_s && last_beat_s) begin
          state_s = HAS_GAP ? ST_GAP : ST_IDLE;
        end else begin
          state_s = ST_PAYLOAD;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_GAP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Payload beat counter; holds while the FIFO underflows mid-frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt_r <= {BEAT_W{1'b0}};
    end else if (hdr_hs_s) begin
      beat_cnt_r <= {BEAT_W{1'b0}};
    end else if (pay_hs_s) begin
      if (last_beat_s) begin
        beat_cnt_r <= {BEAT_W{1'b0}};
      end else begin
        beat_cnt_r <= beat_cnt_r + BEAT_W'(1'b1);
      end
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end

  // Inter-frame gap counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt_r <= {GAP_W{1'b0}};
    end else if (state_r == ST_GAP) begin
      if (gap_cnt_r == GAP_LAST) begin
        gap_cnt_r <= {GAP_W{1'b0}};
      end else begin
        gap_cnt_r <= gap_cnt_r + GAP_W'(1'b1);
      end
    end else begin
      gap_cnt_r <= {GAP_W{1'b0}};
    end
  end

  // Sequence number advances once per completed frame and wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_seq_r <= 16'h0000;
    end else if (pay_hs_s && last_beat_s) begin
      frame_seq_r <= frame_seq_r + 16'h0001;
    end else begin
      frame_seq_r <= frame_seq_r;
    end
  end

endmodule

// File: tb/tb_axis_burst_framer.sv
// Directed bench for axis_burst_framer: a queue models the FIFO, a small
// scoreboard predicts header/payload/tlast for every accepted output beat.
module tb_axis_burst_framer;

  localparam int DW = 32;
  localparam int CW = 32;
  localparam int BL = 256;
  localparam int GC = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [DW-1:0] s_tdata, m_tdata;
  logic          s_tvalid, s_tready, m_tvalid, m_tready, m_tlast, pe, busy;
  logic [CW-1:0] count;
  logic [15:0]   fseq;

  logic [DW-1:0] s1_tdata, m1_tdata;
  logic          s1_tvalid, s1_tready, m1_tvalid, m1_tready, m1_tlast, pe1, busy1;
  logic [CW-1:0] count1;
  logic [15:0]   fseq1;

  axis_burst_framer #(.DATA_W(DW), .COUNT_W(CW), .BURST_LEN(BL), .GAP_CYCLES(GC),
                      .SYNC(16'hA5C3)) dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .fifo_rd_data_count(count), .fifo_prog_empty(pe),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .frame_seq(fseq), .busy(busy));

  axis_burst_framer #(.DATA_W(DW), .COUNT_W(CW), .BURST_LEN(1), .GAP_CYCLES(0),
                      .SYNC(16'hA5C3)) dut1 (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s1_tdata), .s_axis_tvalid(s1_tvalid), .s_axis_tready(s1_tready),
    .fifo_rd_data_count(count1), .fifo_prog_empty(pe1),
    .m_axis_tdata(m1_tdata), .m_axis_tvalid(m1_tvalid), .m_axis_tready(m1_tready),
    .m_axis_tlast(m1_tlast), .frame_seq(fseq1), .busy(busy1));

  int n_vec = 0;
  int n_err = 0;
  int q[$];
  int next_val = 0;
  int exp_seq = 0, exp_pos = 0, exp_data = 0;
  int pops = 0, frames_seen = 0, tlast_seen = 0, cyc = 0;
  int last_hdr_cyc = 0, period = 0, stall_left = 0, stall_seen = 0;
  int pops0, fs0, pops1;
  bit slow_sink = 1'b0;
  bit prev_pend = 1'b0;
  logic [DW-1:0] prev_data, last_hdr;
  logic o_mvalid, o_busy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int n);
    repeat (n) begin
      q.push_back(next_val);
      next_val++;
    end
  endtask

  // One clock of the main DUT, entered and left at a falling edge.
  task automatic step();
    logic s_pop, m_hs, stalled;
    stalled  = (stall_left > 0) && (exp_pos == 101);
    s_tvalid = (q.size() > 0) && !stalled;
    s_tdata  = (q.size() > 0) ? q[0] : 32'h0;
    count    = q.size();
    pe       = (q.size() == 0);
    m_tready = slow_sink ? (cyc % 101 == 0) : 1'b1;
    #1;
    m_hs     = m_tvalid && m_tready;
    s_pop    = s_tready && s_tvalid;
    o_mvalid = m_tvalid;
    o_busy   = busy;
    if (stalled) begin
      check("underflow_valid", m_tvalid, 1'b0);
      stall_left--;
      stall_seen++;
    end
    if (prev_pend) begin
      check("hold_valid", m_tvalid, 1'b1);
      check("hold_data", m_tdata, prev_data);
    end
    prev_pend = m_tvalid && !m_tready;
    prev_data = m_tdata;
    check("pop", s_pop, m_hs && (exp_pos != 0));
    if (m_hs) begin
      if (exp_pos == 0) begin
        check("header", m_tdata, {16'hA5C3, exp_seq[15:0]});
        check("header_tlast", m_tlast, 1'b0);
        last_hdr     = m_tdata;
        period       = cyc - last_hdr_cyc;
        last_hdr_cyc = cyc;
        exp_pos      = 1;
      end else begin
        check("payload", m_tdata, exp_data);
        check("tlast", m_tlast, exp_pos == BL);
        if (m_tlast) tlast_seen++;
        exp_data++;
        if (exp_pos == BL) begin
          exp_pos = 0;
          exp_seq++;
          frames_seen++;
        end else begin
          exp_pos++;
        end
      end
    end
    @(negedge clk);
    cyc++;
    if (s_pop) begin
      void'(q.pop_front());
      pops++;
    end
  endtask

  initial begin
    reset = 1'b1;
    s_tdata = '0; s_tvalid = 1'b0; count = '0; pe = 1'b1; m_tready = 1'b1;
    s1_tdata = '0; s1_tvalid = 1'b0; count1 = '0; pe1 = 1'b1; m1_tready = 1'b1;
    @(negedge clk);
    check("rst_s_tready", s_tready, 1'b0);
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_m_tdata", m_tdata, 32'h0);
    check("rst_m_tlast", m_tlast, 1'b0);
    check("rst_frame_seq", fseq, 16'h0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;

    // One beat short of a burst: must stay idle.
    push(255);
    repeat (20) step();
    check("short_busy", o_busy, 1'b0);
    check("short_pops", pops, 0);
    check("short_seq", fseq, 16'h0);
    // Threshold reached now: header two cycles later.
    push(1);
    step();
    check("lat_n_valid", o_mvalid, 1'b0);
    step();
    check("lat_n1_valid", o_mvalid, 1'b0);
    check("lat_n1_busy", o_busy, 1'b0);
    step();
    check("lat_n2_valid", o_mvalid, 1'b1);
    check("lat_n2_hdr", last_hdr, 32'hA5C30000);

    // Remaining 512 beats: three back-to-back frames.
    push(512);
    for (int i = 0; i < 3000 && frames_seen < 3; i++) step();
    check("three_frames", frames_seen, 3);
    check("three_seq", fseq, 16'd3);
    check("three_tlast", tlast_seen, 3);
    check("three_pops", pops, 768);
    check("three_data_end", exp_data, 768);
    check("frame_period", period, 1 + BL + GC + 2);

    // Slow sink: ready one cycle in 101.
    slow_sink = 1'b1;
    pops0 = pops;
    push(256);
    for (int i = 0; i < 40000 && frames_seen < 4; i++) step();
    slow_sink = 1'b0;
    check("slow_frames", frames_seen, 4);
    check("slow_seq", fseq, 16'd4);
    check("slow_pops", pops - pops0, 256);
    check("slow_fifo_empty", q.size(), 0);

    // Source underflow for 10 cycles at payload beat 100.
    stall_left = 10;
    stall_seen = 0;
    push(256);
    for (int i = 0; i < 2000 && frames_seen < 5; i++) step();
    check("uf_stall_cycles", stall_seen, 10);
    check("uf_frames", frames_seen, 5);
    check("uf_seq", fseq, 16'd5);
    check("uf_tlast", tlast_seen, 5);

    // Reset at payload beat 50.
    push(256);
    for (int i = 0; i < 2000 && exp_pos != 51; i++) step();
    check("mid_reached", exp_pos, 51);
    reset = 1'b1;
    #1;
    check("mid_rst_s_tready", s_tready, 1'b0);
    check("mid_rst_m_tvalid", m_tvalid, 1'b0);
    check("mid_rst_m_tdata", m_tdata, 32'h0);
    check("mid_rst_m_tlast", m_tlast, 1'b0);
    check("mid_rst_seq", fseq, 16'h0);
    check("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    exp_seq = 0; exp_pos = 0; exp_data = q[0]; prev_pend = 1'b0;
    fs0 = frames_seen;
    repeat (10) step();
    check("post_rst_idle", o_busy, 1'b0);
    push(256);
    for (int i = 0; i < 2000 && frames_seen < fs0 + 1; i++) step();
    check("post_rst_hdr", last_hdr, 32'hA5C30000);
    check("post_rst_seq", fseq, 16'd1);

    // BURST_LEN=1, no gap, continuous data: H P idle idle H P ...
    count1 = 100; pe1 = 1'b0; s1_tvalid = 1'b1; pops1 = 0;
    for (int t = 0; t < 18; t++) begin
      int  ph;
      bit  act, hdr;
      s1_tdata = pops1;
      #1;
      ph  = t - 2;
      act = (t >= 2) && (ph % 4 < 2);
      hdr = act && (ph % 4 == 0);
      check("b1_valid", m1_tvalid, act);
      check("b1_ready", s1_tready, act && !hdr);
      if (act) begin
        check("b1_data", m1_tdata, hdr ? {16'hA5C3, 16'(ph / 4)} : 32'(ph / 4));
        check("b1_tlast", m1_tlast, !hdr);
      end
      if (s1_tready && s1_tvalid) pops1++;
      @(negedge clk);
    end
    check("b1_seq", fseq1, 16'd4);
    check("b1_pops", pops1, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
